muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Multi-cycle RV32M execution unit. It consumes the 5-bit alu_control codes 01010–10001 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) from the ALU control decoder.
- Multiply uses an iterative radix-2 shift-add datapath.
- Divide and remainder use an iterative restoring divider.
- A start/busy/done handshake lets the pipeline stall the EX stage while the unit runs.
- The single-cycle ALU still handles codes 00000–01001.

Parameters:
XLEN  32  operand/result width; only 32 is verified; iteration counter width = clog2(XLEN)+1

Ports:
clk           input   1     clock; all state updates on rising edge
rst           input   1     reset, synchronous, active-high
start         input   1     request; sampled only in IDLE
alu_control   input   5     op code from ALU control decoder; sampled with start
op_a          input   XLEN  rs1 value (multiplicand / dividend); sampled with start
op_b          input   XLEN  rs2 value (multiplier / divisor); sampled with start
kill          input   1     pipeline flush; aborts the operation in flight
busy          output  1     high while an accepted operation is iterating
done          output  1     one-cycle pulse; result valid this cycle
result        output  XLEN  registered result; held until the next accepted start

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0; internal registers cleared. Reset mid-operation aborts the operation with no done.
- Accept rule: in IDLE with start=1 and alu_control in 01010..10001, the unit latches the op and operands at edge N.
  - start with any other code is ignored: no busy, no done.
  - start while busy or in DONE is ignored; operands are not re-sampled.
- States:
  - IDLE -> MUL (MUL codes) or DIV (DIV/REM codes) on accept.
  - IDLE -> DONE directly on a divide special case.
  - MUL/DIV -> DONE after XLEN iterations.
  - DONE -> IDLE unconditionally next edge.
  - Any state -> IDLE on kill (no done). kill has priority over completion. kill in IDLE is a no-op.
- Normal latency: busy=1 during cycles N+1..N+32. At edge N+33 the unit enters DONE: done=1, busy=0, result updated. done lasts exactly one cycle.
- Special-case latency: at edge N+1 the unit enters DONE with done=1; busy never asserts.
- start in the DONE cycle is ignored. The earliest back-to-back start is sampled in the following IDLE cycle.
- Sign handling:
  - Operands are converted to magnitudes at accept.
  - MUL/MULH: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - MULHU/DIVU/REMU: both operands unsigned.
  - DIV: quotient negated if sign(a) xor sign(b).
  - REM: remainder takes sign(a).
- Multiply: 2*XLEN-bit unsigned product of magnitudes, conditionally negated as a 64-bit value.
  - MUL returns low XLEN bits.
  - MULH/MULHSU/MULHU return high XLEN bits.
- Divide: restoring, one quotient bit per cycle, MSB first, with a XLEN+1-bit partial remainder.
- Special cases (RISC-V defined, no trap), detected at accept:
  - divisor=0: DIV/DIVU -> all ones; REM/REMU -> op_a.
  - signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- result changes only on entry to DONE. Aborted operations leave result at its previous value.

Test Plan:
1. MUL op_a=7, op_b=0xFFFFFFFD, start at edge N -> busy high for 32 cycles; done at N+33 with result=0xFFFFFFEB.
2. Multiply highs:
   - MULH 0x80000000 x 0x80000000 -> 0x40000000.
   - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
3. Divide:
   - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
   - REM same operands -> 0xFFFFFFFF.
   - DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
   - REMU 100 / 7 -> 2.
4. Special cases, each with done at N+1 and busy never high:
   - DIV 5 / 0 -> 0xFFFFFFFF.
   - REMU 5 / 0 -> 5.
   - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
   - REM same operands -> 0.
5. Abort and reset: start DIV, pulse start with new operands at N+5 -> ignored. kill at N+10 -> IDLE next edge, no done, result unchanged. Repeat with rst at N+10 -> busy=0, result=0.
6. Non-M code and back-to-back:
   - start with alu_control=00000 -> no busy, no done.
   - Two MULs issued back-to-back at the earliest legal cycle -> two done pulses 34 cycles apart, each with the correct result.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Multiplies with radix-2 shift-add and divides with a restoring divider,
// one bit per cycle, behind a start/busy/done handshake.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      alu_control,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [4:0] OP_MUL    = 5'b01010;
    localparam logic [4:0] OP_MULH   = 5'b01011;
    localparam logic [4:0] OP_MULHSU = 5'b01100;
    localparam logic [4:0] OP_MULHU  = 5'b01101;
    localparam logic [4:0] OP_DIV    = 5'b01110;
    localparam logic [4:0] OP_DIVU   = 5'b01111;
    localparam logic [4:0] OP_REM    = 5'b10000;
    localparam logic [4:0] OP_REMU   = 5'b10001;

    localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO_W    = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [XLEN-1:0]     mcand_q, mcand_d;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   acc_q, acc_d;         // product, or quotient in the low half
    logic [XLEN:0]       rem_q, rem_d;         // partial remainder
    logic                neg_q, neg_d;         // negate final result
    logic                sel_q, sel_d;         // high half (mul) or remainder (div)
    logic [XLEN-1:0]     result_q, result_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Decoded accept-time information
    logic                op_valid_s, is_div_s, sign_a_s, sign_b_s, sel_s;
    logic                neg_a_s, neg_b_s, neg_s, special_s, div_zero_s, div_ovf_s;
    logic [XLEN-1:0]     mag_a_s, mag_b_s, spec_val_s;

    // Iteration datapath
    logic [XLEN:0]       mul_sum_s;
    logic [2*XLEN-1:0]   mul_next_s, mul_signed_s;
    logic [XLEN:0]       div_shift_s, div_diff_s, div_rem_next_s;
    logic                div_ge_s;
    logic [XLEN-1:0]     div_quo_next_s, div_res_s, mul_res_s;

    // Decode the op code into operand signedness and result selection.
    always_comb begin
        op_valid_s = 1'b1;
        is_div_s   = 1'b0;
        sign_a_s   = 1'b0;
        sign_b_s   = 1'b0;
        sel_s      = 1'b0;
        case (alu_control)
            OP_MUL:    begin sign_a_s = 1'b1; sign_b_s = 1'b1; end
            OP_MULH:   begin sign_a_s = 1'b1; sign_b_s = 1'b1; sel_s = 1'b1; end
            OP_MULHSU: begin sign_a_s = 1'b1; sel_s = 1'b1; end
            OP_MULHU:  begin sel_s = 1'b1; end
            OP_DIV:    begin is_div_s = 1'b1; sign_a_s = 1'b1; sign_b_s = 1'b1; end
            OP_DIVU:   begin is_div_s = 1'b1; end
            OP_REM:    begin is_div_s = 1'b1; sign_a_s = 1'b1; sign_b_s = 1'b1; sel_s = 1'b1; end
            OP_REMU:   begin is_div_s = 1'b1; sel_s = 1'b1; end
            default:   begin op_valid_s = 1'b0; end
        endcase
    end

    // Operand magnitudes, result sign, and the RISC-V divide special cases.
    always_comb begin
        neg_a_s    = sign_a_s & op_a[XLEN-1];
        neg_b_s    = sign_b_s & op_b[XLEN-1];
        mag_a_s    = neg_a_s ? -op_a : op_a;
        mag_b_s    = neg_b_s ? -op_b : op_b;
        // Remainder follows the dividend; everything else uses sign(a)^sign(b).
        neg_s      = (is_div_s && sel_s) ? neg_a_s : (neg_a_s ^ neg_b_s);
        div_zero_s = (op_b == ZERO_W);
        div_ovf_s  = sign_a_s && (op_a == MIN_NEG) && (op_b == ALL_ONES);
        special_s  = is_div_s && (div_zero_s || div_ovf_s);
        if (div_zero_s) begin
            spec_val_s = sel_s ? op_a : ALL_ONES;
        end else begin
            spec_val_s = sel_s ? ZERO_W : MIN_NEG;
        end
    end

    // One shift-add multiply step and one restoring divide step.
    always_comb begin
        mul_sum_s      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
        mul_next_s     = {mul_sum_s, acc_q[XLEN-1:1]};
        mul_signed_s   = neg_q ? -mul_next_s : mul_next_s;
        mul_res_s      = sel_q ? mul_signed_s[2*XLEN-1:XLEN] : mul_signed_s[XLEN-1:0];
        div_shift_s    = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
        div_diff_s     = div_shift_s - {1'b0, mcand_q};
        div_ge_s       = ~div_diff_s[XLEN];
        div_rem_next_s = div_ge_s ? div_diff_s : div_shift_s;
        div_quo_next_s = {acc_q[XLEN-2:0], div_ge_s};
        if (sel_q) begin
            div_res_s = neg_q ? -div_rem_next_s[XLEN-1:0] : div_rem_next_s[XLEN-1:0];
        end else begin
            div_res_s = neg_q ? -div_quo_next_s : div_quo_next_s;
        end
    end

    // Next-state logic: accept, iterate, complete, or abort on kill.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        neg_d    = neg_q;
        sel_d    = sel_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (!kill && start && op_valid_s) begin
                    neg_d = neg_s;
                    sel_d = sel_s;
                    cnt_d = CNT_ZERO;
                    rem_d = {(XLEN+1){1'b0}};
                    if (special_s) begin
                        state_d  = S_DONE;
                        result_d = spec_val_s;
                    end else if (is_div_s) begin
                        state_d = S_DIV;
                        mcand_d = mag_b_s;
                        acc_d   = {ZERO_W, mag_a_s};
                    end else begin
                        state_d = S_MUL;
                        mcand_d = mag_a_s;
                        acc_d   = {ZERO_W, mag_b_s};
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = mul_next_s;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == LAST_ITER) begin
                        state_d  = S_DONE;
                        result_d = mul_res_s;
                    end else begin
                        state_d = S_MUL;
                    end
                end
            end
            S_DIV: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = {ZERO_W, div_quo_next_s};
                    rem_d = div_rem_next_s;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == LAST_ITER) begin
                        state_d  = S_DONE;
                        result_d = div_res_s;
                    end else begin
                        state_d = S_DIV;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_MUL) || (state_d == S_DIV);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= CNT_ZERO;
            mcand_q  <= ZERO_W;
            acc_q    <= {(2*XLEN){1'b0}};
            rem_q    <= {(XLEN+1){1'b0}};
            neg_q    <= 1'b0;
            sel_q    <= 1'b0;
            result_q <= ZERO_W;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            neg_q    <= neg_d;
            sel_q    <= sel_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven, hand-sequenced and randomized checks of muldiv_unit
// against an arithmetic reference model.
module tb_muldiv_unit;
    localparam logic [4:0] OP_MUL    = 5'b01010;
    localparam logic [4:0] OP_MULH   = 5'b01011;
    localparam logic [4:0] OP_MULHSU = 5'b01100;
    localparam logic [4:0] OP_MULHU  = 5'b01101;
    localparam logic [4:0] OP_DIV    = 5'b01110;
    localparam logic [4:0] OP_DIVU   = 5'b01111;
    localparam logic [4:0] OP_REM    = 5'b10000;
    localparam logic [4:0] OP_REMU   = 5'b10001;

    typedef struct {
        logic [4:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic        clk, rst, start, kill, busy, done;
    logic [4:0]  alu_control;
    logic [31:0] op_a, op_b, result;

    int total = 0;
    int bad   = 0;
    int busy_cycles = 0;
    int done_pulses = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_control(alu_control),
        .op_a(op_a), .op_b(op_b), .kill(kill),
        .busy(busy), .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy) busy_cycles++;
        if (done) done_pulses++;
    end

    // Reference model: plain 64-bit arithmetic plus the RISC-V divide rules.
    function automatic logic [31:0] model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = 64'sd0;
        case (c)
            OP_MUL:    begin p = sa * sb; return p[31:0]; end
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHSU: begin p = sa * ub; return p[63:32]; end
            OP_MULHU:  begin p = ua * ub; return p[63:32]; end
            OP_DIV:    begin if (b == 32'd0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            OP_DIVU:   begin if (b == 32'd0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            OP_REM:    begin if (b == 32'd0) return a; p = sa % sb; return p[31:0]; end
            OP_REMU:   begin if (b == 32'd0) return a; p = ua % ub; return p[31:0]; end
            default:   return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        bit is_div, ovf;
        is_div = (c >= OP_DIV) && (c <= OP_REMU);
        ovf    = ((c == OP_DIV) || (c == OP_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        return (is_div && ((b == 32'd0) || ovf)) ? 1 : 33;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; alu_control = c; op_a = a; op_b = b;
        @(posedge clk);
        #1;
        start = 1'b0; alu_control = 5'($urandom); op_a = $urandom; op_b = $urandom;
    endtask

    // Watch for done after cycle k0 of an accepted op; check latency, busy, result, pulse width.
    task automatic wait_done(input int k0, input int lat, input logic [31:0] exp, input string nm);
        int busy_n, k;
        bit seen;
        busy_n = 0; seen = 1'b0; k = k0;
        while (!seen && k < k0 + 60) begin
            @(negedge clk);
            k++;
            if (busy) busy_n++;
            if (done) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s_timeout: no done within 60 cycles", nm);
        end else begin
            chk({nm, "_lat"}, k, lat);
            chk({nm, "_busy"}, busy_n, lat - 1 - k0);
            chk({nm, "_res"}, result, exp);
            @(negedge clk);
            chk({nm, "_pulse"}, {31'd0, done}, 32'd0);
            chk({nm, "_hold"}, result, exp);
        end
    endtask

    vec_t vecs[12];
    logic [4:0]  rc;
    logic [31:0] ra, rb, prev;
    int b0, d0, t1, t2;
    bit got;

    initial begin
        vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
        vecs[2]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{OP_DIVU,   32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC, 33};
        vecs[7]  = '{OP_REMU,   32'd100,        32'd7,         32'd2,         33};
        vecs[8]  = '{OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{OP_REMU,   32'd5,          32'd0,         32'd5,         1};
        vecs[10] = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};

        rst = 1'b1; start = 1'b0; kill = 1'b0; alu_control = 5'd0; op_a = 32'd0; op_b = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].code, vecs[i].a, vecs[i].b);
            wait_done(0, vecs[i].lat, vecs[i].exp, "vec");
        end

        // start while busy is ignored; operands are not re-sampled
        issue(OP_DIV, 32'd1000, 32'd7);
        repeat (4) @(negedge clk);
        @(negedge clk);
        start = 1'b1; alu_control = OP_MUL; op_a = 32'd3; op_b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(5, 33, 32'd142, "busy_start");

        // kill mid-operation: back to idle, no done, result unchanged
        prev = result;
        d0 = done_pulses;
        issue(OP_DIV, 32'd999, 32'd4);
        repeat (9) @(negedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        chk("kill_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        chk("kill_no_done", done_pulses - d0, 32'd0);
        chk("kill_result", result, prev);

        // reset mid-operation: busy clears, result cleared, no done
        d0 = done_pulses;
        issue(OP_DIV, 32'd999, 32'd4);
        repeat (9) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result", result, 32'd0);
        repeat (40) @(negedge clk);
        chk("rst_no_done", done_pulses - d0, 32'd0);

        // Non-M codes are ignored
        rc = 5'b00000;
        for (int i = 0; i < 3; i++) begin
            b0 = busy_cycles; d0 = done_pulses;
            issue(rc, 32'd6, 32'd7);
            repeat (40) @(negedge clk);
            chk("nonm_busy", busy_cycles - b0, 32'd0);
            chk("nonm_done", done_pulses - d0, 32'd0);
            rc = (i == 0) ? 5'b01001 : 5'b10010;
        end

        // Back-to-back MULs; start is held through the DONE cycle, which must be ignored
        issue(OP_MUL, 32'd12345, 32'd678);
        got = 1'b0; t1 = 0;
        for (int k = 1; k <= 60 && !got; k++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; t1 = k; end
        end
        chk("b2b_lat1", t1, 32'd33);
        chk("b2b_res1", result, 32'd8369910);
        start = 1'b1; alu_control = OP_MUL; op_a = 32'hFFFF_FFFF; op_b = 32'd3;
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        got = 1'b0; t2 = 0;
        for (int k = 2; k <= 80 && !got; k++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; t2 = k; end
        end
        chk("b2b_gap", t2, 32'd34);
        chk("b2b_res2", result, 32'hFFFF_FFFD);
        @(negedge clk);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rc = 5'(10 + $urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            issue(rc, ra, rb);
            wait_done(0, model_lat(rc, ra, rb), model(rc, ra, rb), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
